// File: rtl/bank_rr_arbiter_pkg.sv
// bank_rr_arbiter shared package
// build defaults and arbitration mode encodings
package bank_rr_arbiter_pkg;

  // keep P and MAP in step with `P/`MAP in parameter.v
  localparam int P         = 2;
  localparam int NREQ_DEF  = 2 * P;
  localparam int NBANK_DEF = 4;
  localparam int MAP_DEF   = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

  // round-robin successor of a requester index
  function automatic int next_ptr(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bank_rr_arbiter_pick.sv
// rr_pick: one bank's round-robin / fixed winner
// double-width masked priority encoder
module rr_pick
  import bank_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0]   base;
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;
  int             hit;

  // requests at or above the start point form the low half
  always_comb begin
    base = (mode == MODE_FIX) ? '0 : ptr;
    mask = '0;
    for (int j = 0; j < N; j++) begin
      mask[j] = (j >= int'(base));
    end
    dbl = {req, req & mask};
  end

  // lowest set bit of the doubled vector, folded mod N
  always_comb begin
    found = 1'b0;
    hit   = 0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        hit   = (i >= N) ? i - N : i;
      end
    end
    if (found) begin
      gnt[hit] = 1'b1;
      idx      = W'(hit);
    end
    any = found;
  end

endmodule

// File: rtl/bank_rr_arbiter.sv
// bank_rr_arbiter: per-bank conflict arbiter
// same-cycle ready, registered bank select bus
module bank_rr_arbiter
  import bank_rr_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBANK = NBANK_DEF,
  parameter int MAP   = MAP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*MAP-1:0]  req_bank_bus,
  output logic [NREQ-1:0]      req_rdy,
  output logic [NBANK*MAP-1:0] sel_bus,
  output logic [NBANK-1:0]     bank_vld,
  output logic [CNT_W-1:0]     conf_cnt,
  output logic                 err
);

  logic [MAP-1:0]  bank   [NREQ];
  logic [NREQ-1:0] in_rng;
  logic [NREQ-1:0] live;
  logic [NREQ-1:0] cand   [NBANK];
  logic [NREQ-1:0] gnt    [NBANK];
  logic [MAP-1:0]  win    [NBANK];
  logic [MAP-1:0]  rr_ptr [NBANK];
  logic [NBANK-1:0] hit;
  logic [NREQ-1:0] gnt_any;
  logic            denied;
  logic            oor;

  // unpack bank indices and flag out-of-range targets
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      bank[j]   = req_bank_bus[j*MAP +: MAP];
      in_rng[j] = int'(bank[j]) < NBANK;
    end
    live = {NREQ{en}} & req_vld;
  end

  // candidate vector per bank
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      cand[b] = '0;
      for (int j = 0; j < NREQ; j++) begin
        cand[b][j] = live[j] && in_rng[j]
                  && (int'(bank[j]) == b);
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    rr_pick #(
      .N (NREQ),
      .W (MAP)
    ) u_pick (
      .req  (cand[b]),
      .ptr  (rr_ptr[b]),
      .mode (mode),
      .gnt  (gnt[b]),
      .idx  (win[b]),
      .any  (hit[b])
    );
  end

  // merge grants; out-of-range requests are accepted and dropped
  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NBANK; b++) begin
      gnt_any = gnt_any | gnt[b];
    end
    req_rdy = live & (gnt_any | ~in_rng);
    denied  = |(live & in_rng & ~gnt_any);
    oor     = |(live & ~in_rng);
  end

  // select bus: winners load, idle banks hold unless cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_bus  <= '0;
      bank_vld <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        bank_vld[b] <= hit[b];
        if (hit[b]) begin
          sel_bus[b*MAP +: MAP] <= win[b];
        end else if (clr) begin
          sel_bus[b*MAP +: MAP] <= '0;
        end
      end
    end
  end

  // round-robin pointers advance past each winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) begin
        rr_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (clr) begin
          rr_ptr[b] <= '0;
        end else if (hit[b] && mode == MODE_RR) begin
          rr_ptr[b] <= MAP'(next_ptr(int'(win[b]), NREQ));
        end
      end
    end
  end

  // saturating count of cycles with a denied request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_cnt <= '0;
    end else if (clr) begin
      conf_cnt <= '0;
    end else if (denied && conf_cnt != '1) begin
      conf_cnt <= conf_cnt + 1'b1;
    end
  end

  // sticky out-of-range flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (oor) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/bank_rr_arbiter.md
Name: bank_rr_arbiter

Overview:
- Sequential successor to the combinational bank-index reverse lookup in front of network_bank_in.
- Accepts NREQ access requests, each with a valid flag and target bank index, and resolves bank conflicts with per-bank round-robin or fixed-priority arbitration.
- Returns a same-cycle ready to each requester and presents a registered per-bank select bus (requester index plus valid) to the bank input network.
- Counts conflict cycles for performance monitoring.

Parameters:
- NREQ, 4, number of requesters (2*P in the current build).
- NBANK, 4, number of banks; must be ≥1.
- MAP, 2, index width; must satisfy 2^MAP ≥ max(NREQ, NBANK).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable.
- mode  in  1  0 = per-bank round-robin; 1 = fixed priority, lowest requester index wins.
- clr  in  1  synchronous clear of pointers, counter and error flag.
- req_vld  in  NREQ  per-requester request valid.
- req_bank_bus  in  NREQ*MAP  packed bank indices; requester j occupies bits [j*MAP +: MAP].
- req_rdy  out  NREQ  combinational grant/accept, same cycle as req_vld.
- sel_bus  out  NBANK*MAP  registered; bank b field holds the granted requester index.
- bank_vld  out  NBANK  registered; bank b has a granted access this cycle.
- conf_cnt  out  CNT_W  saturating count of cycles with at least one denied valid request.
- err  out  1  sticky flag: out-of-range bank index seen.

Behaviour:
- Reset (rst_n=0, asynchronous), and clr=1 at a clock edge:
  - sel_bus=0, bank_vld=0, conf_cnt=0, err=0.
  - All rr_ptr[b]=0.
- Handshake: a request j transfers when req_vld[j] && req_rdy[j]. A denied requester must hold req_vld and req_bank stable until accepted.
- Candidate set for bank b: all j with req_vld[j]=1 and bank[j]==b.
- Grant rule, en=1:
  - Round-robin mode: winner is the first candidate at or after rr_ptr[b], scanning upward modulo NREQ.
  - Fixed mode: winner is the lowest candidate index.
  - At most one grant per bank per cycle. Each requester targets one bank, so it receives at most one grant.
- req_rdy[j]=1 iff j is a winner for its bank, or its index is out of range (see below).
- Latency: one cycle. At the edge following the grant, sel_bus[b] = winner and bank_vld[b] = 1.
- Banks with no winner: bank_vld[b]=0 and sel_bus[b] holds its previous value.
- Pointer update: in round-robin mode on a grant, rr_ptr[b] <= (winner+1) mod NREQ. Pointers hold in fixed mode and on banks with no grant.
- Out-of-range index (bank[j] ≥ NBANK with req_vld[j]=1):
  - The request is dropped: req_rdy[j]=1, no bank access.
  - err is set at the next edge and stays set until reset or clr.
- Conflict counter: at an edge with en=1, increment conf_cnt if any valid in-range request was denied. Saturate at 2^CNT_W-1; no wrap.
- en=0: req_rdy all 0, bank_vld becomes 0 at the next edge, pointers and counter hold, err is not updated.
- clr=1 together with valid requests: grants still occur combinationally and bank_vld/sel_bus register normally. Pointers, counter and err take their cleared values, and clr takes priority over updates in that cycle.
- No combinational path from any output to any input other than req_vld/req_bank/en/mode → req_rdy.

Decomposition:
- Shared package: MAP/NREQ/NBANK defaults derived from P (keep in step with `P/`MAP in parameter.v), plus the mode encoding constants MODE_RR=0 and MODE_FIX=1.
- One sub-module, rr_pick: per-bank NREQ-bit request vector plus pointer → one-hot/index winner. Implemented as a double-width masked priority encoder, instantiated NBANK times.

Test Plan:
- Conflict-free: NREQ=NBANK=4, mode=0, req_vld=1111, banks {j0:2, j1:0, j2:3, j3:1} → req_rdy=1111; next cycle bank_vld=1111, sel_bus bank0=1, bank1=3, bank2=0, bank3=2; conf_cnt stays 0.
- Full conflict, round-robin: all four requesters target bank 1 and hold until accepted → grants to 0,1,2,3 on consecutive cycles; bank_vld[1]=1 for 4 cycles; conf_cnt=3; rr_ptr[1]=0 at end.
- Fixed priority: mode=1, requesters 1 and 3 permanently request bank 2 → req_rdy=0010 every cycle, sel_bus bank2=1, conf_cnt increments each cycle; rr_ptr[2] unchanged.
- Async reset mid-stream: drop rst_n between clock edges during the full-conflict sequence → bank_vld/sel_bus/conf_cnt go to 0 immediately; after release, requester 0 is granted first.
- Saturation and clear: CNT_W=4, persistent two-way conflict for 20 cycles → conf_cnt sticks at 15; pulse clr → conf_cnt=0 next cycle.
- Enable and error: NBANK=3, requester 2 sends bank 3 → req_rdy[2]=1, err=1 next cycle, no bank_vld. Then en=0 with valid requests → req_rdy=0000, bank_vld=000 next cycle, err stays 1.
